// File: rtl/exec_pkg.sv
// Shared encodings for the multi-cycle execute stage: ALU opcodes, forwarding
// selects and the stage FSM states.
package exec_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_SLT  = 3'd4,
    ALU_MUL  = 3'd5,
    ALU_DIVU = 3'd6,
    ALU_REMU = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_MEMWB = 2'd1,
    FWD_EXMEM = 2'd2
  } fwd_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Opcodes that go through the iterative multiply/divide core.
  function automatic logic is_iter_op(input alu_op_e op);
    return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/exec_muldiv_iter.sv
// Iterative multiply (shift-add) and unsigned divide (restoring) core.
// One step per cycle; o_done flags the cycle in which the final step completes.
module exec_muldiv_iter
  import exec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  alu_op_e          i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  logic             r_active;
  logic             r_is_mul;
  logic             r_is_rem;
  logic [CNT_W-1:0] r_cnt;
  // MUL: r_acc = product, r_a = multiplicand (<<), r_b = multiplier (>>).
  // DIV: r_acc = partial remainder, r_a = dividend shifting into quotient, r_b = divisor.
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;

  logic [WIDTH-1:0] w_mul_acc;
  logic [WIDTH:0]   w_div_shift;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_div_sub;
  logic [WIDTH-1:0] w_div_rem;
  logic [WIDTH-1:0] w_div_quo;

  always_comb begin
    w_mul_acc   = r_b[0] ? (r_acc + r_a) : r_acc;
    w_div_shift = {r_acc, r_a[WIDTH-1]};
    w_div_ge    = (w_div_shift >= {1'b0, r_b});
    // When w_div_ge holds the difference is below the divisor, so the low bits suffice.
    w_div_sub   = w_div_shift[WIDTH-1:0] - r_b;
    w_div_rem   = w_div_ge ? w_div_sub : w_div_shift[WIDTH-1:0];
    w_div_quo   = {r_a[WIDTH-2:0], w_div_ge};
  end

  assign o_done   = r_active && (r_cnt == LAST_STEP);
  assign o_result = r_is_mul ? w_mul_acc : (r_is_rem ? w_div_rem : w_div_quo);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_active <= 1'b0;
      r_is_mul <= 1'b0;
      r_is_rem <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_a      <= '0;
      r_b      <= '0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_is_mul <= (i_op == ALU_MUL);
      r_is_rem <= (i_op == ALU_REMU);
      r_cnt    <= '0;
      r_acc    <= '0;
      r_a      <= i_a;
      r_b      <= i_b;
    end else if (r_active) begin
      if (r_is_mul) begin
        r_acc <= w_mul_acc;
        r_a   <= r_a << 1;
        r_b   <= r_b >> 1;
      end else begin
        r_acc <= w_div_rem;
        r_a   <= w_div_quo;
      end
      if (r_cnt == LAST_STEP) begin
        r_active <= 1'b0;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/exec_stage_mc.sv
// Execute stage: operand forwarding, immediate select, single-cycle ALU and
// an iterative mul/div path, with valid/ready handshakes on both sides.
module exec_stage_mc
  import exec_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  readData1,
  input  logic [WIDTH-1:0]  readData2,
  input  logic [WIDTH-1:0]  imm,
  input  logic              ctrlAluSrc,
  input  logic [2:0]        aluCtrl,
  input  logic [REG_AW-1:0] rs_IDEX,
  input  logic [REG_AW-1:0] rt_IDEX,
  input  logic [REG_AW-1:0] rd_EXMEM,
  input  logic [REG_AW-1:0] rd_MEMWB,
  input  logic              regWrite_EXMEM,
  input  logic              regWrite_MEMWB,
  input  logic [WIDTH-1:0]  result_EXMEM,
  input  logic [WIDTH-1:0]  valueToWB,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  result,
  output logic              zero,
  output logic              busy
);

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;

  alu_op_e          w_op;
  logic             w_accept;
  logic             w_is_iter;
  fwd_sel_e         w_fwd1;
  fwd_sel_e         w_fwd2;
  logic [WIDTH-1:0] w_op1;
  logic [WIDTH-1:0] w_op2;
  logic [WIDTH-1:0] w_alu;
  logic             w_md_done;
  logic [WIDTH-1:0] w_md_result;

  assign w_op      = alu_op_e'(aluCtrl);
  assign w_is_iter = is_iter_op(w_op);
  assign in_ready  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state == ST_ITER);
  assign result    = r_result;
  assign zero      = r_zero;

  // EX/MEM is the younger producer, so it wins; register 0 is never forwarded.
  always_comb begin
    w_fwd1 = FWD_REG;
    if (regWrite_EXMEM && (rd_EXMEM != '0) && (rd_EXMEM == rs_IDEX))
      w_fwd1 = FWD_EXMEM;
    else if (regWrite_MEMWB && (rd_MEMWB != '0) && (rd_MEMWB == rs_IDEX))
      w_fwd1 = FWD_MEMWB;

    w_fwd2 = FWD_REG;
    if (!ctrlAluSrc) begin
      if (regWrite_EXMEM && (rd_EXMEM != '0) && (rd_EXMEM == rt_IDEX))
        w_fwd2 = FWD_EXMEM;
      else if (regWrite_MEMWB && (rd_MEMWB != '0) && (rd_MEMWB == rt_IDEX))
        w_fwd2 = FWD_MEMWB;
    end
  end

  always_comb begin
    unique case (w_fwd1)
      FWD_EXMEM: w_op1 = result_EXMEM;
      FWD_MEMWB: w_op1 = valueToWB;
      default:   w_op1 = readData1;
    endcase
    if (ctrlAluSrc) begin
      w_op2 = imm;
    end else begin
      unique case (w_fwd2)
        FWD_EXMEM: w_op2 = result_EXMEM;
        FWD_MEMWB: w_op2 = valueToWB;
        default:   w_op2 = readData2;
      endcase
    end
  end

  always_comb begin
    w_alu = '0;
    unique case (w_op)
      ALU_ADD: w_alu = w_op1 + w_op2;
      ALU_SUB: w_alu = w_op1 - w_op2;
      ALU_AND: w_alu = w_op1 & w_op2;
      ALU_OR:  w_alu = w_op1 | w_op2;
      ALU_SLT: w_alu = {{(WIDTH-1){1'b0}}, ($signed(w_op1) < $signed(w_op2))};
      default: w_alu = '0;
    endcase
  end

  exec_muldiv_iter #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_accept && w_is_iter),
    .i_op    (w_op),
    .i_a     (w_op1),
    .i_b     (w_op2),
    .o_done  (w_md_done),
    .o_result(w_md_result)
  );

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_accept) w_state_next = w_is_iter ? ST_ITER : ST_DONE;
      ST_ITER: if (w_md_done) w_state_next = ST_DONE;
      ST_DONE: begin
        if (out_ready) begin
          if (w_accept) w_state_next = w_is_iter ? ST_ITER : ST_DONE;
          else          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_result <= '0;
      r_zero   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept && !w_is_iter) begin
        r_result <= w_alu;
        r_zero   <= (w_alu == '0);
      end else if ((r_state == ST_ITER) && w_md_done) begin
        r_result <= w_md_result;
        r_zero   <= (w_md_result == '0);
      end
    end
  end

endmodule

// File: tb/tb_exec_stage_mc.sv
// Self-checking bench for exec_stage_mc: directed transactions pinned to
// hand-computed literals plus randomized traffic against a transaction model.
module tb_exec_stage_mc;

  localparam int W  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  readData1 = '0, readData2 = '0, imm = '0;
  logic          ctrlAluSrc = 1'b0;
  logic [2:0]    aluCtrl = '0;
  logic [AW-1:0] rs_IDEX = '0, rt_IDEX = '0, rd_EXMEM = '0, rd_MEMWB = '0;
  logic          regWrite_EXMEM = 1'b0, regWrite_MEMWB = 1'b0;
  logic [W-1:0]  result_EXMEM = '0, valueToWB = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  result;
  logic          zero;
  logic          busy;

  exec_stage_mc #(.WIDTH(W), .REG_AW(AW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .readData1(readData1), .readData2(readData2), .imm(imm),
    .ctrlAluSrc(ctrlAluSrc), .aluCtrl(aluCtrl),
    .rs_IDEX(rs_IDEX), .rt_IDEX(rt_IDEX), .rd_EXMEM(rd_EXMEM), .rd_MEMWB(rd_MEMWB),
    .regWrite_EXMEM(regWrite_EXMEM), .regWrite_MEMWB(regWrite_MEMWB),
    .result_EXMEM(result_EXMEM), .valueToWB(valueToWB),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Transaction model: at most one instruction in flight, whose result becomes
  // visible at m_done and stays until consumed with out_ready.
  bit          m_has = 1'b0;
  bit          m_acc = 1'b0;
  logic [W-1:0] m_res = '0;
  int          m_done = 0;

  function automatic bit exp_valid();
    return m_has && (cyc >= m_done);
  endfunction

  function automatic bit exp_busy();
    return m_has && (cyc < m_done);
  endfunction

  function automatic bit exp_ready();
    return !m_has || (exp_valid() && out_ready);
  endfunction

  function automatic logic [W-1:0] fwd(input logic [AW-1:0] r, input logic [W-1:0] v);
    if (r != 0 && regWrite_EXMEM && rd_EXMEM == r) return result_EXMEM;
    if (r != 0 && regWrite_MEMWB && rd_MEMWB == r) return valueToWB;
    return v;
  endfunction

  function automatic logic [W-1:0] model_op();
    logic [W-1:0] a, b, p;
    a = fwd(rs_IDEX, readData1);
    b = ctrlAluSrc ? imm : fwd(rt_IDEX, readData2);
    case (aluCtrl)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return ($signed(a) < $signed(b)) ? 1 : 0;
      3'd5: begin p = a * b; return p; end
      3'd6: return (b == 0) ? '1 : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
  endtask

  task automatic compare_all();
    check("in_ready", 32'(in_ready), 32'(exp_ready()));
    check("out_valid", 32'(out_valid), 32'(exp_valid()));
    check("busy", 32'(busy), 32'(exp_busy()));
    if (exp_valid()) begin
      check("result", result, m_res);
      check("zero", 32'(zero), 32'(m_res == 0));
    end
  endtask

  task automatic step();
    bit ev, ir;
    @(posedge clk);
    ev = exp_valid();
    ir = exp_ready();
    m_acc = 1'b0;
    if (ev && out_ready) m_has = 1'b0;
    if (in_valid && ir) begin
      m_has  = 1'b1;
      m_acc  = 1'b1;
      m_res  = model_op();
      m_done = cyc + ((aluCtrl >= 3'd5) ? W + 1 : 1);
    end
    @(negedge clk);
    cyc++;
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    m_has = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    reset = 1'b0;
  endtask

  task automatic set_ops(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    readData1 = a; readData2 = b; aluCtrl = op; ctrlAluSrc = 1'b0; imm = '0;
    rs_IDEX = 5'd1; rt_IDEX = 5'd2; rd_EXMEM = '0; rd_MEMWB = '0;
    regWrite_EXMEM = 1'b0; regWrite_MEMWB = 1'b0;
  endtask

  task automatic run_one(input string name, input logic [W-1:0] exp_res,
                         input int exp_lat, input int exp_busy_n);
    int g, acc_cyc, busy_n;
    g = 0; busy_n = 0;
    in_valid = 1'b1;
    do begin step(); g++; end while (!m_acc && g < 50);
    in_valid = 1'b0;
    acc_cyc = cyc - 1;
    if (busy) busy_n++;
    g = 0;
    while (!out_valid && g < 100) begin
      step(); g++;
      if (busy) busy_n++;
    end
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_latency"}, 32'(cyc - acc_cyc), 32'(exp_lat));
    check({name, "_result"}, result, exp_res);
    check({name, "_zero"}, 32'(zero), 32'(exp_res == 0));
    check({name, "_busy_cycles"}, 32'(busy_n), 32'(exp_busy_n));
    $display("txn %s: result=%h latency=%0d busy_cycles=%0d", name, result, cyc - acc_cyc, busy_n);
  endtask

  initial begin
    do_reset();

    set_ops(32'd5, 32'd7, 3'd0);
    run_one("add_5_7", 32'd12, 1, 0);

    set_ops(32'h1111, 32'h5555, 3'd0);
    ctrlAluSrc = 1'b1; imm = '0;
    rs_IDEX = 5'd3; rd_EXMEM = 5'd3; rd_MEMWB = 5'd3;
    regWrite_EXMEM = 1'b1; regWrite_MEMWB = 1'b1;
    result_EXMEM = 32'hAA; valueToWB = 32'hBB;
    run_one("fwd_exmem_wins", 32'hAA, 1, 0);
    rs_IDEX = 5'd0;
    run_one("fwd_r0_never", 32'h1111, 1, 0);
    rs_IDEX = 5'd3; regWrite_EXMEM = 1'b0;
    run_one("fwd_memwb", 32'hBB, 1, 0);
    regWrite_EXMEM = 1'b1; rs_IDEX = 5'd0; readData1 = 32'd1;
    rt_IDEX = 5'd3; ctrlAluSrc = 1'b0;
    run_one("fwd_op2", 32'hAB, 1, 0);
    ctrlAluSrc = 1'b1; imm = 32'h10;
    run_one("imm_not_forwarded", 32'h11, 1, 0);

    set_ops(32'hFFFF_FFFF, 32'd3, 3'd5);
    run_one("mul", 32'hFFFF_FFFD, 33, 32);
    set_ops(32'd100, 32'd7, 3'd6);
    run_one("divu", 32'd14, 33, 32);
    set_ops(32'd100, 32'd7, 3'd7);
    run_one("remu", 32'd2, 33, 32);
    set_ops(32'd9, 32'd0, 3'd6);
    run_one("divu_by0", 32'hFFFF_FFFF, 33, 32);
    set_ops(32'd9, 32'd0, 3'd7);
    run_one("remu_by0", 32'd9, 33, 32);
    set_ops(32'hFFFF_FFFE, 32'd1, 3'd4);
    run_one("slt_neg", 32'd1, 1, 0);

    // Backpressure: SUB 4-4 held for 5 cycles, then back-to-back accept.
    step();
    out_ready = 1'b0;
    set_ops(32'd4, 32'd4, 3'd1);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    check("bp_result", result, 32'd0);
    check("bp_zero", 32'(zero), 32'd1);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    $display("txn backpressure: result=%h zero=%0d held", result, zero);
    set_ops(32'd1, 32'd2, 3'd0);
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    step();
    check("bp_b2b_accept", 32'(m_acc), 32'd1);
    in_valid = 1'b0;
    check("bp_b2b_result", result, 32'd3);
    step();

    // Reset in the middle of a multiply.
    set_ops(32'hFFFF_FFFF, 32'd3, 3'd5);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (9) step();
    do_reset();
    set_ops(32'd2, 32'd3, 3'd0);
    run_one("add_after_reset", 32'd5, 1, 0);

    for (int i = 0; i < 600; i++) begin
      in_valid   = ($urandom_range(0, 2) != 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      aluCtrl    = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      readData1  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      readData2  = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom);
      imm        = $urandom;
      ctrlAluSrc = 1'($urandom_range(0, 1));
      rs_IDEX    = 5'($urandom_range(0, 3));
      rt_IDEX    = 5'($urandom_range(0, 3));
      rd_EXMEM   = 5'($urandom_range(0, 3));
      rd_MEMWB   = 5'($urandom_range(0, 3));
      regWrite_EXMEM = 1'($urandom_range(0, 1));
      regWrite_MEMWB = 1'($urandom_range(0, 1));
      result_EXMEM   = $urandom;
      valueToWB      = $urandom;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (40) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/exec_stage_mc.md
# exec_stage_mc

Parametrised multi-cycle execute stage for the pipelined core: resolves EX/MEM and MEM/WB operand forwarding, selects register or immediate second operand, and computes single-cycle ALU ops or iterative multiply/divide. It sits between the ID/EX and EX/MEM pipeline registers and uses a valid/ready handshake on both sides, so upstream stages stall while a long operation is in flight.

## Interface
Parameters:
- WIDTH, 32, datapath width in bits (≥ 4)
- REG_AW, 5, register-address width

Ports:
- clk  in  1  stage clock, rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  ID/EX holds a valid instruction
- in_ready  out  1  stage accepts the instruction this cycle
- readData1, readData2  in  WIDTH  register-file operands
- imm  in  WIDTH  sign-extended immediate
- ctrlAluSrc  in  1  0: op2 = readData2, 1: op2 = imm
- aluCtrl  in  3  operation (see Operation)
- rs_IDEX, rt_IDEX  in  REG_AW  source register numbers
- rd_EXMEM, rd_MEMWB  in  REG_AW  destination numbers of older instructions
- regWrite_EXMEM, regWrite_MEMWB  in  1  older instructions write back
- result_EXMEM, valueToWB  in  WIDTH  forwardable values
- out_valid  out  1  result/zero valid
- out_ready  in  1  EX/MEM register accepts result
- result  out  WIDTH  operation result
- zero  out  1  result == 0
- busy  out  1  multiply/divide iteration in progress

## Operation
- Accept occurs when in_valid && in_ready. All operands, forwarding decisions and aluCtrl are captured on that edge; later changes on inputs are ignored.
- Forwarding per operand: EX/MEM match (regWrite_EXMEM, rd_EXMEM ≠ 0, rd_EXMEM == rs/rt) wins over MEM/WB match; otherwise register value. Register 0 is never forwarded. Operand-2 forwarding applies only when ctrlAluSrc = 0; imm is never overridden.
- aluCtrl: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT (signed, result 1 or 0), 5 MUL (low WIDTH bits, unsigned/signed identical), 6 DIVU quotient, 7 REMU remainder. ADD/SUB wrap modulo 2^WIDTH.
- Divide by zero: DIVU returns all ones, REMU returns the dividend. No exception.
- FSM: IDLE → DONE on accept of ops 0–4; IDLE → ITER on accept of ops 5–7; ITER → DONE after WIDTH iteration steps (shift-add for MUL, restoring shift-subtract for DIVU/REMU); DONE → IDLE when out_ready and no new accept; DONE → DONE/ITER when out_ready and a new accept happens in the same cycle.
- in_ready = (state == IDLE) || (state == DONE && out_ready).
- out_valid = (state == DONE); result/zero held stable while out_valid && !out_ready.
- busy = (state == ITER).

## Timing
- Reset: state IDLE, out_valid 0, result 0, zero 0, busy 0, iteration counter 0; in_ready therefore 1.
- Single-cycle ops: accept in cycle N, out_valid and result in cycle N+1.
- MUL/DIVU/REMU: accept in cycle N, busy in cycles N+1..N+WIDTH, out_valid in cycle N+WIDTH+1.
- Throughput: one single-cycle op per cycle when out_ready is held high.
- Reset asserted mid-iteration: abort immediately, return to reset values; partial result discarded.
- out_ready low in DONE: state and result frozen indefinitely; in_ready 0.

## Structure
- Package exec_pkg: aluCtrl encodings, forward-select enum (FWD_REG, FWD_MEMWB, FWD_EXMEM), FSM state enum.
- Sub-module exec_muldiv_iter: iterative multiply/divide core (start, op, a, b → done, result), WIDTH-parametrised, same clk/reset.
- Forwarding and simple ALU stay combinational inside exec_stage_mc.

## Test plan
- ADD, WIDTH=32: readData1=5, readData2=7, aluCtrl=0, no forwarding → out_valid one cycle later, result=12, zero=0.
- Forward priority: rs_IDEX=3, rd_EXMEM=3, rd_MEMWB=3, both regWrite=1, result_EXMEM=0xAA, valueToWB=0xBB, op ADD with op2=0 → result=0xAA; repeat with rs=0 → result=readData1.
- MUL: 0xFFFF_FFFF × 3 → out_valid exactly 33 cycles after accept, result=0xFFFF_FFFD, busy high for 32 cycles.
- DIVU/REMU: 100/7 → 14, remainder 2; divisor 0 with dividend 9 → 0xFFFF_FFFF and 9.
- Backpressure: out_ready=0 for 5 cycles after SUB 4−4 → result=0, zero=1 held, in_ready=0; out_ready=1 with new in_valid → back-to-back accept.
- Reset during MUL iteration at cycle 10 → all outputs to reset values next sample, in_ready=1, subsequent ADD correct.
